// File: rtl/altsqrt_iter.sv
// Sequential restoring integer square root: floor(sqrt(data)) and data - root^2,
// one root bit per enabled clock, with a start/busy/done handshake.
module altsqrt_iter #(
  parameter int    data_width     = 16,
  parameter string representation = "UNSIGNED",
  parameter string lpm_type       = "altsqrt_iter",
  localparam int   RW             = (data_width + 1) / 2,
  localparam int   REMW           = RW + 1
) (
  input  logic                  clock,
  input  logic                  sclr,
  input  logic                  ena,
  input  logic                  start,
  input  logic [data_width-1:0] data,
  output logic                  busy,
  output logic                  done,
  output logic [RW-1:0]         root,
  output logic [REMW-1:0]       remainder,
  output logic                  neg_err
);
  localparam int  OW        = 2 * RW;
  localparam int  CW        = (RW > 1) ? $clog2(RW) : 1;
  localparam bit  IS_SIGNED = (representation == "SIGNED");

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nx;
  logic [OW-1:0]   opnd;
  logic [REMW-1:0] prem;
  logic [RW-1:0]   proot;
  logic [CW-1:0]   cnt;
  logic            accept, neg_in, last;
  logic [REMW+1:0] cat_rem, sub, trial;
  logic [REMW-1:0] rem_nx;
  logic [RW-1:0]   root_nx;

  assign neg_in = IS_SIGNED && data[data_width-1];
  assign last   = (cnt == '0);

  // The sign bit of trial tells whether the next root bit is 1; partials are
  // bounded so the widened subtraction never overflows into it.
  always_comb begin
    cat_rem = {prem, opnd[OW-1 -: 2]};
    sub     = {1'b0, proot, 2'b01};
    trial   = cat_rem - sub;
    rem_nx  = trial[REMW+1] ? cat_rem[REMW-1:0] : trial[REMW-1:0];
    root_nx = RW'({proot, ~trial[REMW+1]});
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    if (ena) begin
      case (state)
        IDLE, DONE: if (start) begin
          accept   = 1'b1;
          state_nx = neg_in ? DONE : CALC;
        end
        CALC:       if (last) state_nx = DONE;
        default:    state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (sclr) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      opnd      <= '0;
      prem      <= '0;
      proot     <= '0;
      cnt       <= '0;
      root      <= '0;
      remainder <= '0;
      neg_err   <= 1'b0;
    end else if (ena) begin
      if (accept) begin
        neg_err <= neg_in;
        if (neg_in) begin
          root      <= '0;
          remainder <= '0;
        end else begin
          opnd  <= OW'(data);
          prem  <= '0;
          proot <= '0;
          cnt   <= CW'(RW - 1);
        end
      end else if (state == CALC) begin
        opnd  <= opnd << 2;
        prem  <= rem_nx;
        proot <= root_nx;
        cnt   <= cnt - 1'b1;
        if (last) begin
          root      <= root_nx;
          remainder <= rem_nx;
        end
      end
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);
endmodule

// File: doc/altsqrt_iter.md
Name: altsqrt_iter

Overview:
- Sequential integer square-root unit: the inverse of the team's parameterised square megafunction.
- Computes floor(sqrt(data)) and the remainder data - root^2 using a restoring digit-by-digit algorithm, one root bit per enabled clock.
- Sits beside the square block in datapaths that need magnitude/normalisation. A start/busy/done handshake connects it to a controlling FSM.

Parameters:
- data_width, 16, input operand width; minimum 1; odd widths allowed (operand zero-extended by one MSB internally).
- representation, "UNSIGNED", "UNSIGNED" or "SIGNED"; in SIGNED mode a negative operand raises neg_err.
- lpm_type, "altsqrt_iter", type identification string only.
- Derived (not overridable):
  - RW = (data_width+1)/2, root width.
  - REMW = RW+1, remainder width.

Ports:
- clock  input  1  rising-edge clock.
- sclr  input  1  synchronous active-high reset.
- ena  input  1  clock enable; 0 freezes all state except sclr.
- start  input  1  request; sampled only when ena=1 and the unit is not busy.
- data  input  data_width  operand; captured on the accepting edge.
- busy  output  1  high while iterating.
- done  output  1  high while results are valid; held until next accepted start.
- root  output  RW  floor(sqrt(data)).
- remainder  output  REMW  data - root*root, range 0..2*root.
- neg_err  output  1  SIGNED mode only: operand was negative.

Behaviour:
- Reset: sclr=1 at any edge (regardless of ena) forces:
  - state=IDLE; busy=0, done=0, neg_err=0;
  - root=0, remainder=0; iteration counter=0.
  - Reset mid-operation discards the computation; no done is produced.
- States: IDLE, CALC, DONE. All transitions happen only on edges with ena=1.
- Accept: in IDLE or DONE, start=1 captures data and clears done and neg_err.
  - SIGNED mode, data[MSB]=1: go to DONE next edge with neg_err=1, root=0, remainder=0; busy stays 0.
  - Otherwise: load operand register (zero-extended to 2*RW), partial remainder=0, partial root=0, counter=RW-1, busy=1; go to CALC.
- CALC, per enabled edge:
  - trial = (rem<<2 | top two operand bits) - (root<<2 | 1), computed REMW+2 bits wide.
  - If trial is non-negative: rem=trial, root=(root<<1)|1. Else: rem=rem<<2|bits, root=root<<1.
  - Shift operand left by 2; decrement counter.
  - When counter=0 on an iteration edge: go to DONE, busy=0, done=1, root/remainder outputs updated from the final partials on the same edge.
- Latency: done rises exactly RW enabled edges after the accepting edge (16-bit operand: 8 edges). Throughput: one result per RW+1 enabled edges with back-to-back start.
- start while busy: ignored, not queued.
- start in DONE: accepted; done drops on that edge.
- ena=0 during CALC: stall with no state change; latency counts enabled edges only.
- Outputs root/remainder change only on the final CALC edge, the neg_err edge, or sclr. Intermediate partials are never visible.
- data changes after the accepting edge have no effect.

Test Plan:
- data_width=16, data=144, start one cycle -> busy for 8 edges, then done=1, root=12, remainder=0; done held until next start.
- data_width=16, data=65535 -> root=255, remainder=510. Then data=0 -> root=0, remainder=0. Then data=2 -> root=1, remainder=1, each issued back-to-back from DONE.
- data_width=7, data=127 -> root=11, remainder=6 after 4 enabled edges. Random sweep against a reference model: root^2+remainder==data, remainder<=2*root.
- ena toggled 0/1 every other cycle during CALC for data=1000 -> done only after 8 enabled edges; root=31, remainder=39; outputs frozen while ena=0.
- start pulsed again at cycle 3 of CALC with data=9 -> ignored, result is the first operand's. sclr at cycle 4 of a new computation -> busy=0, done=0, root=0, remainder=0 next edge; no spurious done.
- representation="SIGNED", data_width=8, data=-4 -> one edge later done=1, neg_err=1, root=0, remainder=0. Then data=49 -> neg_err cleared, root=7, remainder=0.
